cpu_step_ctrl: RTL and testbench
================================

# cpu_step_ctrl

Run/step controller for the single-cycle LEGv8 datapath on the DE2-70 board. It debounces the step, mode and speed push-buttons and runs a three-state run controller (manual, auto-run, halted). It issues a one-cycle execute enable that the datapath samples on the 50 MHz board clock. This replaces the free-running divided clocks and the raw key-toggled clock muxing with a glitch-free, single-clock-domain sequencer that also supports a PC breakpoint.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable samples required to accept a key level.
- SLOW_DIV, 10000000: iCLK cycles between enables in slow auto-run.
- FAST_DIV, 31: iCLK cycles between enables in fast auto-run.
- PC_W, 64: PC width.

Ports:
- iCLK, input, 1: 50 MHz board clock; the only clock.
- iReset_n, input, 1: synchronous, active-low reset.
- iKeyStep, input, 1: raw step key, active-low, asynchronous.
- iKeyMode, input, 1: raw manual/auto toggle key, active-low, asynchronous.
- iKeySpeed, input, 1: raw slow/fast toggle key, active-low, asynchronous.
- iBreakEn, input, 1: breakpoint enable (switch level, synchronised internally).
- iBreakPC, input, PC_W: breakpoint address.
- iPC, input, PC_W: current datapath PC.
- oCPUEn, output, 1: one-cycle execute enable to the datapath.
- oState, output, 2: 0 = MANUAL, 1 = RUN, 2 = HALT.
- oFast, output, 1: 1 = fast auto speed.
- oCycleCount, output, 32: count of issued enables.

## Operation
- Key path, identical for each key:
  - 2-flop synchroniser.
  - Saturating stability counter: the accepted level updates only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce clears the counter.
  - A press event is a 1→0 change of the accepted level; the event pulse lasts exactly one cycle.
- Speed event: in any state, toggles oFast and clears the divider counter.
- Divider: counts 0..DIV-1 while in RUN, where DIV = oFast ? FAST_DIV : SLOW_DIV. It fires when count == DIV-1, then wraps to 0. It is held at 0 outside RUN.
- MANUAL state:
  - Step event → oCPUEn pulse.
  - Mode event → RUN, sets bp_skip.
- RUN state:
  - On divider fire, breakpoint hit (iBreakEn && iPC == iBreakPC && !bp_skip) → HALT, no pulse.
  - On divider fire otherwise → oCPUEn pulse, clears bp_skip.
  - Mode event → MANUAL.
  - Step events are ignored.
- HALT state:
  - Step event → one oCPUEn pulse, then MANUAL.
  - Mode event → RUN with bp_skip set, so execution can resume past the breakpoint instruction.
- Simultaneous events: a mode event takes priority over a step event in the same cycle, and the step event is dropped. A speed event is independent of both.
- A mode event and a divider fire in the same RUN cycle: the mode event wins, no pulse, go to MANUAL.
- oCycleCount increments on every oCPUEn pulse and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - oState = MANUAL, oFast = 0, oCPUEn = 0, oCycleCount = 0.
  - Divider = 0, bp_skip = 0.
  - Accepted key levels = 1 (released); stability counters = 0.
- Reset mid-operation: all state returns to the reset values on the next edge. Any pending debounce is discarded. A key held through reset produces an event only after release and a new press.
- Key latency: a clean press produces its event 2 + DEBOUNCE_CYCLES cycles after the raw falling edge.
- oCPUEn is registered: it is high exactly one cycle after the event or divider fire that causes it, and is never high on two consecutive cycles.
- State transitions take effect on the same edge that registers the corresponding oCPUEn.
- iPC is compared combinationally in the fire cycle.
- RUN enable period is exactly DIV cycles. The first pulse after entering RUN comes DIV cycles after the entry edge.

## Configuration
- CLKCTRL_BREAKPOINT_EN defined:
  - Breakpoint comparator, bp_skip and the HALT state are present as described above.
- CLKCTRL_BREAKPOINT_EN undefined:
  - iBreakEn and iBreakPC are ignored; HALT is unreachable.
  - oState only takes the values 0 and 1; no comparator logic is generated.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, SLOW_DIV = 8, FAST_DIV = 3.
- Reset, then a step key press bouncing 1-0-1-0 with 2-cycle gaps, then held low → exactly one oCPUEn pulse, 7 cycles after the final falling edge; oCycleCount = 1.
- Mode press from MANUAL → oState = 1; oCPUEn pulses every 8 cycles. Speed press → period becomes 3; oFast = 1.
- RUN with iBreakEn = 1, iPC driven to match iBreakPC = 0x40 → no pulse at that fire, oState = 2. Step press → one pulse, oState = 0.
- From HALT with iPC still 0x40, mode press → first fire issues a pulse (skip); the next fire with iPC = 0x40 halts again.
- Mode and step events in the same cycle in MANUAL → oState = 1, no oCPUEn pulse.
- Preload oCycleCount = 0xFFFFFFFF via stepping (forced), one more pulse → 0. Assert iReset_n low mid-RUN for 1 cycle → oState = 0, oFast = 0, oCPUEn = 0.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - run/step sequencer with debounced keys; breakpoint and HALT present when CLKCTRL_BREAKPOINT_EN is defined
// Single clock domain: the datapath samples the one-cycle oCPUEn on iCLK.

module cpu_step_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Until a released level has been seen after reset, a key held through reset cannot fire.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    level_d = level_q;
    armed_d = armed_q | sync2_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (armed_q && (sync2_q != level_q)) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b1;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;
endmodule

module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SLOW_DIV        = 10000000,
  parameter int FAST_DIV        = 31,
  parameter int PC_W            = 64
) (
  input  logic            iCLK,
  input  logic            iReset_n,
  input  logic            iKeyStep,
  input  logic            iKeyMode,
  input  logic            iKeySpeed,
  input  logic            iBreakEn,
  input  logic [PC_W-1:0] iBreakPC,
  input  logic [PC_W-1:0] iPC,
  output logic            oCPUEn,
  output logic [1:0]      oState,
  output logic            oFast,
  output logic [31:0]     oCycleCount
);
  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  localparam int DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int DW      = (DIV_MAX < 2) ? 1 : $clog2(DIV_MAX);

  logic step_ev, mode_ev, speed_ev;

  cpu_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk(iCLK), .resetn(iReset_n), .key_n(iKeyStep), .press(step_ev)
  );
  cpu_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(iCLK), .resetn(iReset_n), .key_n(iKeyMode), .press(mode_ev)
  );
  cpu_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
    .clk(iCLK), .resetn(iReset_n), .key_n(iKeySpeed), .press(speed_ev)
  );

  state_e          state_q, state_d;
  logic            en_q, en_d;
  logic            fast_q, fast_d;
  logic [DW-1:0]   div_q, div_d;
  logic [DW-1:0]   div_last;
  logic [31:0]     cycle_count_q, cycle_count_d;
  logic            fire;
  logic            bp_hit;

`ifdef CLKCTRL_BREAKPOINT_EN
  logic brk_sync1_q, brk_sync1_d;
  logic brk_sync2_q, brk_sync2_d;
  logic bp_skip_q, bp_skip_d;

  assign brk_sync1_d = iBreakEn;
  assign brk_sync2_d = brk_sync1_q;
  assign bp_hit      = brk_sync2_q && (iPC == iBreakPC) && !bp_skip_q;

  always_ff @(posedge iCLK) begin
    if (!iReset_n) begin
      brk_sync1_q <= 1'b0;
      brk_sync2_q <= 1'b0;
      bp_skip_q   <= 1'b0;
    end else begin
      brk_sync1_q <= brk_sync1_d;
      brk_sync2_q <= brk_sync2_d;
      bp_skip_q   <= bp_skip_d;
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{iBreakEn, iBreakPC, iPC};
  assign bp_hit    = 1'b0;
`endif

  // Mode beats step and divider fire; speed is handled independently of both.
  always_comb begin
    state_d  = state_q;
    en_d     = 1'b0;
    fast_d   = fast_q ^ speed_ev;
    div_last = fast_q ? DW'(FAST_DIV - 1) : DW'(SLOW_DIV - 1);
    fire     = (state_q == ST_RUN) && (div_q == div_last);
`ifdef CLKCTRL_BREAKPOINT_EN
    bp_skip_d = bp_skip_q;
`endif
    case (state_q)
      ST_MANUAL: begin
        if (mode_ev) begin
          state_d = ST_RUN;
`ifdef CLKCTRL_BREAKPOINT_EN
          bp_skip_d = 1'b1;
`endif
        end else if (step_ev) begin
          en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (mode_ev) begin
          state_d = ST_MANUAL;
        end else if (fire) begin
          if (bp_hit) begin
            state_d = ST_HALT;
          end else begin
            en_d = 1'b1;
`ifdef CLKCTRL_BREAKPOINT_EN
            bp_skip_d = 1'b0;
`endif
          end
        end
      end
`ifdef CLKCTRL_BREAKPOINT_EN
      ST_HALT: begin
        if (mode_ev) begin
          state_d   = ST_RUN;
          bp_skip_d = 1'b1;
        end else if (step_ev) begin
          en_d    = 1'b1;
          state_d = ST_MANUAL;
        end
      end
`endif
      default: state_d = ST_MANUAL;
    endcase

    if (speed_ev || fire || (state_q != ST_RUN) || (state_d != ST_RUN)) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
    cycle_count_d = cycle_count_q + {31'd0, en_d};
  end

  always_ff @(posedge iCLK) begin
    if (!iReset_n) begin
      state_q       <= ST_MANUAL;
      en_q          <= 1'b0;
      fast_q        <= 1'b0;
      div_q         <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      fast_q        <= fast_d;
      div_q         <= div_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign oCPUEn      = en_q;
  assign oState      = state_q;
  assign oFast       = fast_q;
  assign oCycleCount = cycle_count_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - randomized key/PC stimulus against an event-level model of cpu_step_ctrl
// Key events are predicted from the falling-edge time; run pulses from absolute fire times.

module tb_cpu_step_ctrl;
  localparam int D    = 4;
  localparam int SLOW = 8;
  localparam int FAST = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_step = 1'b1, key_mode = 1'b1, key_speed = 1'b1;
  logic        brk_en = 1'b1;
  logic [63:0] brk_pc = 64'h40;
  logic [63:0] pc = 64'h0;
  logic        en, fast;
  logic [1:0]  st;
  logic [31:0] ccount;

  always #5 clk = ~clk;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(D), .SLOW_DIV(SLOW), .FAST_DIV(FAST), .PC_W(64)
  ) dut (
    .iCLK(clk), .iReset_n(rst_n), .iKeyStep(key_step), .iKeyMode(key_mode),
    .iKeySpeed(key_speed), .iBreakEn(brk_en), .iBreakPC(brk_pc), .iPC(pc),
    .oCPUEn(en), .oState(st), .oFast(fast), .oCycleCount(ccount)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit pc_rand = 1'b0;

  int q_step[$];
  int q_mode[$];
  int q_speed[$];

  logic [1:0]  m_state = 2'd0;
  logic        m_fast  = 1'b0;
  logic        m_skip  = 1'b0;
  logic        m_en    = 1'b0;
  logic [31:0] m_count = 32'd0;
  int          m_next  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // State after edge `cyc`; inputs still hold the values seen by that edge.
  task automatic model_edge();
    bit s, m, p, fire, bp;
    logic [1:0] old;
    int n;
    n = cyc;
    if (!rst_n) begin
      m_state = 2'd0; m_fast = 1'b0; m_skip = 1'b0; m_en = 1'b0; m_count = 32'd0;
      q_step.delete(); q_mode.delete(); q_speed.delete();
      return;
    end
    s = (q_step.size()  > 0) && (q_step[0]  == n - 1);
    m = (q_mode.size()  > 0) && (q_mode[0]  == n - 1);
    p = (q_speed.size() > 0) && (q_speed[0] == n - 1);
    if (s) void'(q_step.pop_front());
    if (m) void'(q_mode.pop_front());
    if (p) void'(q_speed.pop_front());
    old  = m_state;
    m_en = 1'b0;
    fire = (m_state == 2'd1) && (n == m_next);
    bp   = 1'b0;
`ifdef CLKCTRL_BREAKPOINT_EN
    bp = brk_en && (pc == brk_pc) && !m_skip;
`endif
    if (p) m_fast = !m_fast;
    case (m_state)
      2'd0: begin
        if (m) begin m_state = 2'd1; m_skip = 1'b1; end
        else if (s) m_en = 1'b1;
      end
      2'd1: begin
        if (m) m_state = 2'd0;
        else if (fire) begin
          if (bp) m_state = 2'd2;
          else begin m_en = 1'b1; m_skip = 1'b0; end
        end
      end
      default: begin
        if (m) begin m_state = 2'd1; m_skip = 1'b1; end
        else if (s) begin m_en = 1'b1; m_state = 2'd0; end
      end
    endcase
    if (m_en) m_count = m_count + 32'd1;
    if ((m_state == 2'd1) && ((old != 2'd1) || fire || p)) m_next = n + (m_fast ? FAST : SLOW);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    model_edge();
    chk("cpu_en", 32'(en), 32'(m_en));
    chk("state", 32'(st), 32'(m_state));
    chk("fast", 32'(fast), 32'(m_fast));
    chk("cycle_count", ccount, m_count);
    if (pc_rand) pc = ($urandom_range(0, 2) == 0) ? 64'h40 : {32'd0, $urandom};
  endtask

  task automatic drive(input logic [2:0] msk, input logic v);
    if (msk[0]) key_step  = v;
    if (msk[1]) key_mode  = v;
    if (msk[2]) key_speed = v;
  endtask

  // nb short low glitches (g>0 fixes glitch and gap length), then a clean press and release.
  task automatic press(input logic [2:0] msk, input int nb, input int g);
    for (int b = 0; b < nb; b++) begin
      drive(msk, 1'b0);
      repeat ((g > 0) ? g : $urandom_range(1, 2)) tick();
      drive(msk, 1'b1);
      repeat ((g > 0) ? g : $urandom_range(1, 3)) tick();
    end
    drive(msk, 1'b0);
    if (msk[0]) q_step.push_back(cyc + D + 2);
    if (msk[1]) q_mode.push_back(cyc + D + 2);
    if (msk[2]) q_speed.push_back(cyc + D + 2);
    repeat (D + 4) tick();
    drive(msk, 1'b1);
    repeat (D + 4) tick();
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    repeat (ncyc) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_state", 32'(st), 32'd0);
    chk("reset_cycle_count", ccount, 32'd0);
    rst_n = 1'b1;
    repeat (6) tick();

    press(3'b001, 1, 2);
    chk("first_step_count", ccount, 32'd1);

    press(3'b010, 0, 0);
    repeat (20) tick();
    chk("run_state", 32'(st), 32'd1);
    press(3'b100, 0, 0);
    repeat (9) tick();
    chk("fast_set", 32'(fast), 32'd1);

    pc = 64'h40;
    repeat (6) tick();
`ifdef CLKCTRL_BREAKPOINT_EN
    chk("bp_halt", 32'(st), 32'd2);
    press(3'b001, 0, 0);
    chk("halt_step_manual", 32'(st), 32'd0);
    press(3'b010, 0, 0);
    chk("bp_rehalt", 32'(st), 32'd2);
`else
    chk("no_bp_run", 32'(st), 32'd1);
    press(3'b001, 0, 0);
    press(3'b010, 0, 0);
    chk("no_bp_manual", 32'(st), 32'd0);
`endif
    pc = 64'h0;
    for (int k = 0; k < 4 && m_state != 2'd0; k++) press(3'b010, 0, 0);

    press(3'b011, 0, 0);
    chk("mode_step_same_cycle", 32'(st), 32'd1);
    press(3'b010, 0, 0);

    force dut.cycle_count_q = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    tick();
    release dut.cycle_count_q;
    tick();
    press(3'b001, 0, 0);
    chk("count_wrap", ccount, 32'd0);

    press(3'b010, 0, 0);
    repeat (5) tick();
    do_reset(1);
    chk("midrun_reset_state", 32'(st), 32'd0);
    chk("midrun_reset_fast", 32'(fast), 32'd0);
    chk("midrun_reset_en", 32'(en), 32'd0);
    repeat (6) tick();

    drive(3'b001, 1'b0);
    q_step.push_back(cyc + D + 2);
    repeat (D + 4) tick();
    do_reset(1);
    repeat (12) tick();
    drive(3'b001, 1'b1);
    repeat (D + 4) tick();
    press(3'b001, 0, 0);
    chk("held_through_reset", ccount, 32'd1);

    pc_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: press(3'b001, $urandom_range(0, 3), 0);
        1: press(3'b010, $urandom_range(0, 3), 0);
        2: press(3'b100, $urandom_range(0, 3), 0);
        3: press(3'b011, $urandom_range(0, 2), 0);
        4: press(3'b101, $urandom_range(0, 2), 0);
        default: repeat ($urandom_range(1, 20)) tick();
      endcase
    end
    pc_rand = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
